usb_rx_timer: RTL and testbench



---
 rtl/usb_rx_pkg.sv | 12 +
 rtl/usb_rx_timer.sv | 82 ++++++++
 tb/tb_usb_rx_timer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/usb_rx_pkg.sv
// Shared USB receive-path constants: default bit timing and byte framing,
// plus the counter widths derived from them.
package usb_rx_pkg;

    localparam int USB_CLKS_PER_BIT  = 8;
    localparam int USB_SAMPLE_POINT  = 3;
    localparam int USB_BITS_PER_BYTE = 8;

    localparam int USB_PHASE_W  = $clog2(USB_CLKS_PER_BIT + 1);
    localparam int USB_BITCNT_W = $clog2(USB_BITS_PER_BYTE);

endpackage

// File: rtl/usb_rx_timer.sv
// USB RX bit timer: per-bit phase counter resynchronised on line edges,
// one sample strobe per unstuffed bit, and a byte-complete pulse.
module usb_rx_timer
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT  = USB_CLKS_PER_BIT,
    parameter int SAMPLE_POINT  = USB_SAMPLE_POINT,
    parameter int BITS_PER_BYTE = USB_BITS_PER_BYTE
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic                             enable,
    input  logic                             d_edge,
    input  logic                             stuffed,
    output logic                             shift_enable,
    output logic                             byte_received,
    output logic [$clog2(BITS_PER_BYTE)-1:0] bit_cnt
);

    localparam int PH_W = $clog2(CLKS_PER_BIT + 1);
    localparam int BC_W = $clog2(BITS_PER_BYTE);

    // Phase 0 is IDLE; phases 1..CLKS_PER_BIT are RUN.
    localparam logic [PH_W-1:0] PH_IDLE   = '0;
    localparam logic [PH_W-1:0] PH_FIRST  = PH_W'(1);
    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(CLKS_PER_BIT);
    localparam logic [PH_W-1:0] PH_SAMPLE = PH_W'(SAMPLE_POINT);
    localparam logic [BC_W-1:0] BC_LAST   = BC_W'(BITS_PER_BYTE - 1);

    logic [PH_W-1:0] r_phase;
    logic [BC_W-1:0] r_bit_cnt;
    logic            r_byte_received;
    logic            w_sample;
    logic            w_shift;
    logic            w_wrap;

    // Strobes are single-cycle pulses with no back-pressure: the decoder
    // must act on shift_enable in the cycle it is high.
    always_comb begin
        w_sample = enable && (r_phase == PH_SAMPLE);
        w_shift  = w_sample && !stuffed;
        w_wrap   = w_shift && (r_bit_cnt == BC_LAST);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_phase <= PH_IDLE;
        end else if (!enable) begin
            r_phase <= PH_IDLE;
        end else if (r_phase == PH_IDLE || d_edge) begin
            r_phase <= PH_FIRST;
        end else if (r_phase == PH_LAST) begin
            r_phase <= PH_FIRST;
        end else begin
            r_phase <= r_phase + PH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_bit_cnt <= '0;
        end else if (!enable) begin
            r_bit_cnt <= '0;
        end else if (w_shift) begin
            r_bit_cnt <= w_wrap ? '0 : r_bit_cnt + BC_W'(1);
        end
    end

    // A wrap in the same cycle that enable drops is discarded.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_byte_received <= 1'b0;
        end else begin
            r_byte_received <= enable && w_wrap;
        end
    end

    assign shift_enable  = w_shift;
    assign byte_received = r_byte_received;
    assign bit_cnt       = r_bit_cnt;

endmodule

// File: tb/tb_usb_rx_timer.sv
// Self-checking bench for usb_rx_timer: per-cycle model comparison plus
// literal strobe/byte timing lists for each directed scenario.
module tb_usb_rx_timer;
    import usb_rx_pkg::*;

    localparam int CPB = USB_CLKS_PER_BIT;
    localparam int SP  = USB_SAMPLE_POINT;
    localparam int BPB = USB_BITS_PER_BYTE;

    logic                    clk;
    logic                    n_rst;
    logic                    enable;
    logic                    d_edge;
    logic                    stuffed;
    logic                    shift_enable;
    logic                    byte_received;
    logic [USB_BITCNT_W-1:0] bit_cnt;

    int total;
    int bad;
    int cyc;
    int se_q[$];
    int br_q[$];

    usb_rx_timer dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .enable       (enable),
        .d_edge       (d_edge),
        .stuffed      (stuffed),
        .shift_enable (shift_enable),
        .byte_received(byte_received),
        .bit_cnt      (bit_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_list(input string nm, input int base, input int act[$], input int exp[$]);
        chk({nm, "_count"}, act.size(), exp.size());
        for (int i = 0; i < act.size() && i < exp.size(); i++) begin
            chk(nm, act[i] - base, exp[i]);
        end
    endtask

    // ---------------- behavioural model + compare ----------------
    // The model tracks the cycle of the last timing anchor (start of run or
    // accepted edge); the bit phase is the elapsed time modulo the bit period.
    bit m_active;
    int m_anchor;
    int m_cnt;
    bit m_pend;

    initial begin
        int ph;
        bit exp_se;
        bit exp_br;
        int exp_bc;
        m_active = 0;
        m_anchor = 0;
        m_cnt    = 0;
        m_pend   = 0;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                exp_se   = 0;
                exp_br   = 0;
                exp_bc   = 0;
                m_active = 0;
                m_cnt    = 0;
                m_pend   = 0;
            end else begin
                ph     = m_active ? ((cyc - m_anchor - 1) % CPB) + 1 : 0;
                exp_se = enable && (ph == SP) && !stuffed;
                exp_br = m_pend;
                exp_bc = m_cnt;
            end
            chk("shift_enable", int'(shift_enable), int'(exp_se));
            chk("byte_received", int'(byte_received), int'(exp_br));
            chk("bit_cnt", int'(bit_cnt), exp_bc);
            if (shift_enable) se_q.push_back(cyc);
            if (byte_received) br_q.push_back(cyc);
            if (n_rst) begin
                if (!enable) begin
                    m_active = 0;
                    m_cnt    = 0;
                    m_pend   = 0;
                end else begin
                    m_pend = exp_se && (m_cnt == BPB - 1);
                    if (exp_se) m_cnt = (m_cnt + 1) % BPB;
                    if (!m_active || d_edge) begin
                        m_active = 1;
                        m_anchor = cyc;
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic en, input logic de, input logic st);
        enable  = en;
        d_edge  = de;
        stuffed = st;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int t0;
        int exp_se_l[$];
        int exp_br_l[$];
        total   = 0;
        bad     = 0;
        n_rst   = 1'b0;
        enable  = 1'b0;
        d_edge  = 1'b0;
        stuffed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_bit_cnt", int'(bit_cnt), 0);
        chk("reset_shift", int'(shift_enable), 0);
        chk("reset_byte", int'(byte_received), 0);
        n_rst = 1'b1;
        idle(2);

        // Free-running, no edges.
        se_q.delete(); br_q.delete(); exp_se_l.delete(); exp_br_l.delete();
        t0 = cyc;
        for (int i = 0; i < 80; i++) step(1'b1, 1'b0, 1'b0);
        idle(3);
        for (int k = 0; k < 10; k++) exp_se_l.push_back(3 + 8 * k);
        exp_br_l.push_back(60);
        chk_list("t1_shift", t0, se_q, exp_se_l);
        chk_list("t1_byte", t0, br_q, exp_br_l);

        // Single resync edge at cycle 5.
        se_q.delete(); br_q.delete(); exp_se_l.delete();
        t0 = cyc;
        for (int i = 0; i < 21; i++) step(1'b1, logic'(i == 5), 1'b0);
        idle(3);
        exp_se_l = '{3, 8, 16};
        chk_list("t2_shift", t0, se_q, exp_se_l);

        // Stuff bit at the third sample point.
        se_q.delete(); br_q.delete(); exp_se_l.delete(); exp_br_l.delete();
        t0 = cyc;
        for (int i = 0; i < 81; i++) step(1'b1, 1'b0, logic'(i == 19));
        idle(3);
        exp_se_l = '{3, 11, 27, 35, 43, 51, 59, 67, 75};
        exp_br_l.push_back(68);
        chk_list("t3_shift", t0, se_q, exp_se_l);
        chk_list("t3_byte", t0, br_q, exp_br_l);

        // Enable dropped mid-byte, then restarted.
        se_q.delete(); br_q.delete(); exp_se_l.delete();
        t0 = cyc;
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b0);
        chk("t4_bit_cnt_before_drop", int'(bit_cnt), 5);
        step(1'b0, 1'b0, 1'b0);
        chk("t4_bit_cnt_after_drop", int'(bit_cnt), 0);
        chk("t4_shift_after_drop", int'(shift_enable), 0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);
        idle(3);
        exp_se_l = '{3, 11, 19, 27, 35, 45, 53, 61};
        chk_list("t4_shift", t0, se_q, exp_se_l);
        chk("t4_byte_count", br_q.size(), 0);

        // Edges every 7 cycles, then every 9 cycles.
        se_q.delete(); br_q.delete(); exp_se_l.delete(); exp_br_l.delete();
        t0 = cyc;
        for (int i = 0; i < 80; i++) begin
            step(1'b1,
                 logic'((i >= 2 && i <= 37 && (i - 2) % 7 == 0) ||
                        (i >= 44 && (i - 44) % 9 == 0)),
                 1'b0);
        end
        idle(3);
        for (int j = 0; j < 6; j++) exp_se_l.push_back(5 + 7 * j);
        for (int j = 0; j < 4; j++) exp_se_l.push_back(47 + 9 * j);
        exp_br_l.push_back(57);
        chk_list("t5_shift", t0, se_q, exp_se_l);
        chk_list("t5_byte", t0, br_q, exp_br_l);

        // Asynchronous reset mid-byte.
        t0 = cyc;
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b0);
        chk("t6_bit_cnt_before_rst", int'(bit_cnt), 4);
        n_rst = 1'b0;
        #1;
        chk("t6_rst_bit_cnt", int'(bit_cnt), 0);
        chk("t6_rst_shift", int'(shift_enable), 0);
        chk("t6_rst_byte", int'(byte_received), 0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        n_rst = 1'b1;
        se_q.delete(); br_q.delete(); exp_se_l.delete();
        t0 = cyc;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
        idle(3);
        exp_se_l.push_back(3);
        chk_list("t6_shift", t0, se_q, exp_se_l);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
